fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: dual-slot in / dual-slot out first-word fall-through
// instruction queue sitting between fetch and decode. A circular buffer of
// {pc, instr} entries; the two fetch slots push in order, the two decode
// slots pop in order, and a flush discards everything on a redirect.
module fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid_0,
  input  logic                     enq_valid_1,
  input  logic [PC_WIDTH-1:0]      enq_pc_0,
  input  logic [PC_WIDTH-1:0]      enq_pc_1,
  input  logic [INSTR_WIDTH-1:0]   enq_instr_0,
  input  logic [INSTR_WIDTH-1:0]   enq_instr_1,
  output logic                     enq_ready,
  output logic                     deq_valid_0,
  output logic                     deq_valid_1,
  output logic [PC_WIDTH-1:0]      deq_pc_0,
  output logic [PC_WIDTH-1:0]      deq_pc_1,
  output logic [INSTR_WIDTH-1:0]   deq_instr_0,
  output logic [INSTR_WIDTH-1:0]   deq_instr_1,
  input  logic                     deq_ready_0,
  input  logic                     deq_ready_1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0]    r_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic          w_push0;
  logic          w_push1;
  logic          w_pop0;
  logic          w_pop1;
  logic [1:0]    w_npush;
  logic [1:0]    w_npop;

  // Pointers are AW bits wide, so +1/+2 wraps modulo DEPTH for free.
  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);

  // enq_ready depends on registered occupancy only, so there is no
  // combinational path from either handshake side to it.
  assign enq_ready = (r_count <= CW'(DEPTH - 2));
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;

  // Slot 1 only rides along with slot 0; a lone slot 1 valid is dropped.
  assign w_push0 = enq_valid_0 & enq_ready;
  assign w_push1 = w_push0 & enq_valid_1;

  assign deq_valid_0 = (r_count >= CW'(1));
  assign deq_valid_1 = (r_count >= CW'(2));

  // Slot 1 can only pop behind slot 0, keeping decode in program order.
  assign w_pop0 = deq_valid_0 & deq_ready_0;
  assign w_pop1 = deq_valid_1 & deq_ready_1 & deq_ready_0;

  assign w_npush = 2'(w_push0) + 2'(w_push1);
  assign w_npop  = 2'(w_pop0)  + 2'(w_pop1);

  // Fall-through read of the two oldest entries, zeroed when not valid.
  always_comb begin
    deq_pc_0    = '0;
    deq_instr_0 = '0;
    deq_pc_1    = '0;
    deq_instr_1 = '0;
    if (deq_valid_0) begin
      deq_pc_0    = r_pc[r_head];
      deq_instr_0 = r_instr[r_head];
    end
    if (deq_valid_1) begin
      deq_pc_1    = r_pc[w_head1];
      deq_instr_1 = r_instr[w_head1];
    end
  end

  // Entry storage: written only for accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (w_push0) begin
        r_pc[r_tail]    <= enq_pc_0;
        r_instr[r_tail] <= enq_instr_0;
      end
      if (w_push1) begin
        r_pc[w_tail1]    <= enq_pc_1;
        r_instr[w_tail1] <= enq_instr_1;
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_npop);
      r_tail  <= r_tail + AW'(w_npush);
      r_count <= r_count + CW'(w_npush) - CW'(w_npop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus, a scoreboard queue of expected
// entries filled by the driver, and a monitor on the falling edge that
// compares the decode slots, flags and count against the scoreboard.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          enq_valid_0, enq_valid_1;
  logic [PW-1:0] enq_pc_0, enq_pc_1;
  logic [IW-1:0] enq_instr_0, enq_instr_1;
  logic          enq_ready;
  logic          deq_valid_0, deq_valid_1;
  logic [PW-1:0] deq_pc_0, deq_pc_1;
  logic [IW-1:0] deq_instr_0, deq_instr_1;
  logic          deq_ready_0, deq_ready_1;
  logic [3:0]    count;
  logic          full, empty;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid_0(enq_valid_0), .enq_valid_1(enq_valid_1),
    .enq_pc_0(enq_pc_0), .enq_pc_1(enq_pc_1),
    .enq_instr_0(enq_instr_0), .enq_instr_1(enq_instr_1),
    .enq_ready(enq_ready),
    .deq_valid_0(deq_valid_0), .deq_valid_1(deq_valid_1),
    .deq_pc_0(deq_pc_0), .deq_pc_1(deq_pc_1),
    .deq_instr_0(deq_instr_0), .deq_instr_1(deq_instr_1),
    .deq_ready_0(deq_ready_0), .deq_ready_1(deq_ready_1),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  logic [PW+IW-1:0] sb[$];   // expected queue contents, oldest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: before each rising edge, the visible state must match the
  // scoreboard; entries the decode side takes this cycle are retired.
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      n = sb.size();
      chk("mon_count", 64'(count), 64'(n));
      chk("mon_valid0", 64'(deq_valid_0), 64'(n >= 1));
      chk("mon_valid1", 64'(deq_valid_1), 64'(n >= 2));
      chk("mon_full", 64'(full), 64'(n == DEPTH));
      chk("mon_empty", 64'(empty), 64'(n == 0));
      chk("mon_enq_ready", 64'(enq_ready), 64'(n <= DEPTH - 2));
      chk("mon_slot0", {deq_pc_0, deq_instr_0}, (n >= 1) ? sb[0] : 64'h0);
      chk("mon_slot1", {deq_pc_1, deq_instr_1}, (n >= 2) ? sb[1] : 64'h0);
      if (n >= 1 && deq_ready_0) begin
        void'(sb.pop_front());
        if (n >= 2 && deq_ready_1) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus. Acceptance is decided from the scoreboard size
  // before the edge; expected entries are queued right after the edge.
  task automatic cyc(input logic v0, input logic v1,
                     input logic [31:0] pc0, input logic [31:0] in0,
                     input logic [31:0] pc1, input logic [31:0] in1,
                     input logic r0, input logic r1,
                     input logic fl = 1'b0, input logic rn = 1'b1);
    bit acc;
    acc = (sb.size() <= DEPTH - 2);
    enq_valid_0 = v0;  enq_valid_1 = v1;
    enq_pc_0 = pc0;    enq_instr_0 = in0;
    enq_pc_1 = pc1;    enq_instr_1 = in1;
    deq_ready_0 = r0;  deq_ready_1 = r1;
    flush = fl;        rst_n = rn;
    @(posedge clk);
    if (!rn || fl) sb.delete();
    else if (acc && v0) begin
      sb.push_back({pc0, in0});
      if (v1) sb.push_back({pc1, in1});
    end
    #1;
    enq_valid_0 = 0; enq_valid_1 = 0;
    deq_ready_0 = 0; deq_ready_1 = 0;
    flush = 0;       rst_n = 1;
  endtask

  task automatic push2(input logic [31:0] pc);
    cyc(1, 1, pc, {16'hB000, pc[15:0]}, pc + 4, {16'hB000, pc[15:0] + 16'h4}, 0, 0);
  endtask

  task automatic idle(input logic r0, input logic r1);
    cyc(0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  initial begin
    rst_n = 0; flush = 0;
    enq_valid_0 = 0; enq_valid_1 = 0;
    enq_pc_0 = 0; enq_pc_1 = 0; enq_instr_0 = 0; enq_instr_1 = 0;
    deq_ready_0 = 0; deq_ready_1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    chk("rst_count", 64'(count), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_valid", {62'h0, deq_valid_1, deq_valid_0}, 0);
    chk("rst_pc0", 64'(deq_pc_0), 0);
    mon_en = 1;

    // First pair becomes visible the cycle after it is written
    cyc(1, 1, 32'h100, 32'hAAAA0001, 32'h104, 32'hAAAA0002, 0, 0);
    chk("pair_count", 64'(count), 2);
    chk("pair_valid", {62'h0, deq_valid_1, deq_valid_0}, 3);
    chk("pair_pc0", 64'(deq_pc_0), 64'h100);
    chk("pair_pc1", 64'(deq_pc_1), 64'h104);

    // Fill from empty: enq_ready holds at 6, drops at 8; extra push dropped
    idle(0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    push2(32'h200); push2(32'h208); push2(32'h210);
    chk("fill6_count", 64'(count), 6);
    chk("fill6_ready", 64'(enq_ready), 1);
    push2(32'h218);
    chk("fill8_count", 64'(count), 8);
    chk("fill8_ready", 64'(enq_ready), 0);
    chk("fill8_full", 64'(full), 1);
    push2(32'h900);
    chk("over_count", 64'(count), 8);
    chk("over_pc0", 64'(deq_pc_0), 64'h200);

    // Single pops and the ignored lone deq_ready_1
    idle(1, 0);
    chk("pop1_count", 64'(count), 7);
    idle(0, 1);
    chk("r1only_count", 64'(count), 7);
    idle(1, 0);
    chk("pop7_count", 64'(count), 6);
    chk("pop7_ready", 64'(enq_ready), 1);
    chk("pop7_pc0", 64'(deq_pc_0), 64'h208);
    repeat (3) idle(1, 1);
    chk("drain_empty", 64'(empty), 1);

    // Mixed 1/2 pushes with interleaved pops across the wrap point;
    // a lone enq_valid_1 must not enqueue anything.
    for (int k = 0; k < 3; k++) begin
      logic [31:0] b;
      b = 32'h400 + 32'(k) * 32'h40;
      cyc(1, 0, b,        b + 1, 0,        0,     0, 0);
      cyc(1, 1, b + 4,    b + 5, b + 8,    b + 9, 1, 0);
      cyc(0, 1, 32'hDEAD, 1,     32'hBEEF, 2,     0, 0);
      cyc(1, 0, b + 12,   b + 13, 0,       0,     1, 1);
      cyc(1, 1, b + 16,   b + 17, b + 20,  b + 21, 1, 0);
      cyc(1, 1, b + 24,   b + 25, b + 28,  b + 29, 0, 1);
    end
    repeat (6) idle(1, 1);
    chk("wrap_drain_empty", 64'(empty), 1);

    // Flush beats a simultaneous push pair and pops
    push2(32'h500); push2(32'h508);
    cyc(1, 0, 32'h510, 32'h1, 0, 0, 0, 0);
    chk("pre_flush_count", 64'(count), 5);
    cyc(1, 1, 32'h600, 32'h2, 32'h604, 32'h3, 1, 1, 1);
    chk("flush_count", 64'(count), 0);
    chk("flush_empty", 64'(empty), 1);
    chk("flush_valid", {62'h0, deq_valid_1, deq_valid_0}, 0);
    chk("flush_pc0", 64'(deq_pc_0), 0);

    // Reset mid-operation drops all entries
    push2(32'h700); push2(32'h708);
    chk("pre_rst_count", 64'(count), 4);
    cyc(1, 1, 32'h800, 32'h4, 32'h804, 32'h5, 1, 1, 0, 0);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_ready", 64'(enq_ready), 1);
    chk("midrst_instr0", 64'(deq_instr_0), 0);

    // Queue still works afterwards
    push2(32'hC00);
    idle(1, 1);
    chk("final_empty", 64'(empty), 1);
    idle(0, 0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bounded runtime guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
